note_play_scheduler: RTL
========================

Name: note_play_scheduler

Overview:
Sequencer/arbiter for the piano tone generator. It decides whether manual keys or the built-in auto-play song drive the tone datapath, and presents one registered note command (note, octave, valid) per cycle. It sits between the key/switch inputs and the frequency divider. The matrix-LED, seven-segment and LCD drivers also consume its note, mode and position outputs.

Parameters:
BEAT_CYCLES, 12500000, clk cycles per beat (0.25 s at 50 MHz)
GAP_CYCLES, 1250000, silent articulation cycles at the end of each auto note; must satisfy 0 < GAP_CYCLES < BEAT_CYCLES
DEB_CYCLES, 1000000, cycles the key vector must be stable before it is accepted
SONG_LEN, 32, number of ROM entries played before wrap; range 2..32

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
btn  in  7  raw keys; btn[6]=Do … btn[0]=Si; asynchronous to clk
sw  in  2  sw[1]=1 enables sound (0 = mute); sw[0] selects octave (0 = mid, 1 = high) for manual play
auto  in  1  auto-play request, level, asynchronous
note  out  3  0=rest, 1..7 = Do..Si
octave  out  2  0=low, 1=mid, 2=high
note_valid  out  1  tone generator enable
mode  out  1  1 while in any AUTO_* state
beat_idx  out  5  current ROM index
song_done  out  1  one-cycle pulse when the last entry finishes

Behaviour:
- Reset (async, any state or mid-song): state IDLE; note=0, octave=1, note_valid=0, mode=0, beat_idx=0, song_done=0; all counters and synchronizers cleared.
- btn and auto each pass through 2-FF synchronizers.
- Debounce:
  - Any change of the synced btn vector restarts the debounce counter.
  - After DEB_CYCLES consecutive stable cycles, the vector is copied to key_acc.
- Manual key mapping: priority is highest index wins, so btn[6] maps to note 1 and btn[0] maps to note 7.
- Song ROM: 8-bit entries {oct[1:0], note[2:0], dur[2:0]}; length in beats = dur+1. Fixed entries:
  - entry 0 = {1,1,1}: mid Do, 2 beats
  - entry 1 = {1,2,0}: mid Re, 1 beat
  - entry 2 = {1,3,0}: mid Mi, 1 beat
  - entry 3 = {0,0,0}: rest, 1 beat
  - remaining entries are a free melody table.
- States:
  - IDLE: outputs note=0, note_valid=0. Goes to MANUAL when key_acc≠0. Goes to AUTO_LOAD on a synced auto rising edge; this takes precedence over MANUAL in the same cycle.
  - MANUAL: note from key_acc; octave = sw[0] ? 2 : 1; note_valid=1. Updates on the cycle after key_acc changes. key_acc=0 returns to IDLE; auto rising edge goes to AUTO_LOAD.
  - AUTO_LOAD: 1 cycle. Reads ROM[beat_idx] into registers; note_valid=0. Next state AUTO_PLAY.
  - AUTO_PLAY: outputs ROM note/octave; note_valid=1 if note≠0, else 0. Lasts (dur+1)*BEAT_CYCLES−GAP_CYCLES cycles, then AUTO_GAP.
  - AUTO_GAP: note_valid=0 for GAP_CYCLES cycles. At exit:
    - beat_idx==SONG_LEN−1: song_done pulses 1 cycle and beat_idx wraps to 0.
    - otherwise beat_idx increments.
    - Next state is AUTO_LOAD if synced auto=1, else IDLE.
- Auto abort: synced auto=0 in any AUTO_* state goes to IDLE on the next edge with note_valid=0. beat_idx resets to 0 on abort; no song_done is emitted.
- Arbitration: keys are ignored while mode=1. key_acc keeps tracking, so a key still held after auto ends enters MANUAL from IDLE on the next cycle.
- Mute: sw[1]=0 forces note_valid=0 in every state. Sequencing and all other outputs continue unchanged.
- Latency: with auto high at clk edge 1, state is AUTO_LOAD after edge 3 and the first note is valid after edge 4. Per-entry period = (dur+1)*BEAT_CYCLES + 1 cycles.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
Bench parameters: BEAT_CYCLES=16, GAP_CYCLES=2, DEB_CYCLES=4, SONG_LEN=4.
1. Reset mid-AUTO_PLAY → all outputs at reset values immediately (asynchronous); IDLE on release.
2. sw=2'b10; btn=7'b0010000 held 20 cycles with a 1-cycle glitch at cycle 2 → note=3, octave=1, note_valid=1, appearing DEB_CYCLES after the last change + sync + 1 cycle. btn=7'b1010000 → note=1. sw=2'b11 → octave=2. Release all keys → IDLE, note_valid=0.
3. sw=2'b10, auto=1 → after LOAD, note=1/oct=1 valid for 30 cycles, 2 gap cycles, 1 LOAD cycle; then note=2 valid 14; note=3 valid 14; then rest with note_valid=0. After the last gap: song_done pulse, beat_idx=0, replay starts.
4. Press btn=7'b1000000 during auto → outputs unchanged and mode=1. Drop auto with the key still held → IDLE, then MANUAL with note=1.
5. auto=1 with sw=2'b00 → full song cycles with note_valid=0 throughout; beat_idx and song_done behave exactly as in scenario 3.
6. Drop auto during AUTO_GAP of entry 1 → IDLE next cycle, beat_idx=0, no song_done. Raise auto again → restarts at entry 0.

Source files
------------

// File: rtl/note_play_if.sv
// Note command bus between the key/switch front panel and the tone scheduler.
// The master side drives the raw panel inputs; the slave side returns the registered note command.
interface note_play_if;
    logic [6:0] btn;
    logic [1:0] sw;
    logic       auto;
    logic [2:0] note;
    logic [1:0] octave;
    logic       note_valid;
    logic       mode;
    logic [4:0] beat_idx;
    logic       song_done;

    modport master (
        output btn, sw, auto,
        input  note, octave, note_valid, mode, beat_idx, song_done
    );

    modport slave (
        input  btn, sw, auto,
        output note, octave, note_valid, mode, beat_idx, song_done
    );
endinterface

// File: rtl/note_play_scheduler.sv
// Chooses between debounced manual keys and the built-in auto-play song and
// presents one registered note command per cycle to the tone datapath.
module note_play_scheduler #(
    parameter int BEAT_CYCLES = 12500000,
    parameter int GAP_CYCLES  = 1250000,
    parameter int DEB_CYCLES  = 1000000,
    parameter int SONG_LEN    = 32
) (
    input  logic        clk,
    input  logic        rst,
    note_play_if.slave  bus
);
    localparam int          CNT_W    = $clog2(8 * BEAT_CYCLES + 1);
    localparam int          DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [4:0]  LAST_IDX = 5'(SONG_LEN - 1);
    localparam logic [31:0] BEAT_U   = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_U    = 32'(GAP_CYCLES);

    // {oct[1:0], note[2:0], dur[2:0]}; the first four entries are fixed, the rest is a free melody
    localparam logic [7:0] SONG_ROM [32] = '{
        8'h49, 8'h50, 8'h58, 8'h00, 8'h60, 8'h69, 8'h68, 8'h70,
        8'h89, 8'h78, 8'h70, 8'h69, 8'h00, 8'h60, 8'h58, 8'h51,
        8'h48, 8'h28, 8'h30, 8'h38, 8'h49, 8'h00, 8'h58, 8'h68,
        8'h88, 8'h90, 8'h98, 8'h90, 8'h89, 8'h68, 8'h4B, 8'h00
    };

    typedef enum logic [2:0] {
        S_IDLE, S_MANUAL, S_LOAD, S_PLAY, S_GAP
    } state_t;

    logic [6:0]       btn_s1_reg, btn_s2_reg, btn_prev_reg, key_acc_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             auto_s1_reg, auto_s2_reg, auto_prev_reg;
    logic             auto_rise;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [4:0]       beat_idx_reg, beat_idx_next;
    logic             song_done_reg, song_done_next;
    logic [2:0]       note_reg, note_next;
    logic [1:0]       octave_reg, octave_next;
    logic             note_valid_reg, note_valid_next;
    logic             mode_reg, mode_next;

    logic [7:0]       rom_q;
    logic [CNT_W-1:0] play_last;
    logic [6:0]       key_top;
    logic [2:0]       key_code [7];
    logic [2:0]       key_note;
    logic             valid_raw;

    // Synchronizers and debounce: key_acc only follows a vector held stable for DEB_CYCLES
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_s1_reg    <= '0;
            btn_s2_reg    <= '0;
            btn_prev_reg  <= '0;
            key_acc_reg   <= '0;
            deb_cnt_reg   <= '0;
            auto_s1_reg   <= 1'b0;
            auto_s2_reg   <= 1'b0;
            auto_prev_reg <= 1'b0;
        end else begin
            btn_s1_reg    <= bus.btn;
            btn_s2_reg    <= btn_s1_reg;
            btn_prev_reg  <= btn_s2_reg;
            auto_s1_reg   <= bus.auto;
            auto_s2_reg   <= auto_s1_reg;
            auto_prev_reg <= auto_s2_reg;
            if (btn_s2_reg != btn_prev_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_cnt_reg == DEB_LAST) begin
                key_acc_reg <= btn_s2_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    assign auto_rise = auto_s2_reg & ~auto_prev_reg;

    // Highest pressed index wins: btn[6] is Do (1), btn[0] is Si (7)
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_key_prio
            assign key_top[gi]  = key_acc_reg[gi] & ~(|(key_acc_reg >> (gi + 1)));
            assign key_code[gi] = key_top[gi] ? 3'(7 - gi) : 3'd0;
        end
    endgenerate

    always_comb begin
        key_note = 3'd0;
        for (int i = 0; i < 7; i++) begin
            key_note = key_note | key_code[i];
        end
    end

    assign rom_q     = SONG_ROM[beat_idx_reg];
    assign play_last = CNT_W'(({29'd0, rom_q[2:0]} + 32'd1) * BEAT_U - GAP_U - 32'd1);

    // State, sequencing counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= '0;
            beat_idx_reg   <= '0;
            song_done_reg  <= 1'b0;
            note_reg       <= 3'd0;
            octave_reg     <= 2'd1;
            note_valid_reg <= 1'b0;
            mode_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            beat_idx_reg   <= beat_idx_next;
            song_done_reg  <= song_done_next;
            note_reg       <= note_next;
            octave_reg     <= octave_next;
            note_valid_reg <= note_valid_next;
            mode_reg       <= mode_next;
        end
    end

    // Dropping auto in any auto state aborts the song and rewinds to entry 0
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        beat_idx_next  = beat_idx_reg;
        song_done_next = 1'b0;
        case (state_reg)
            S_IDLE, S_MANUAL: begin
                if (auto_rise) begin
                    state_next = S_LOAD;
                end else if (key_acc_reg != 7'd0) begin
                    state_next = S_MANUAL;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_LOAD, S_PLAY, S_GAP: begin
                if (!auto_s2_reg) begin
                    state_next    = S_IDLE;
                    beat_idx_next = 5'd0;
                end else if (state_reg == S_LOAD) begin
                    state_next = S_PLAY;
                    cnt_next   = play_last;
                end else if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (state_reg == S_PLAY) begin
                    state_next = S_GAP;
                    cnt_next   = GAP_LAST;
                end else begin
                    state_next = S_LOAD;
                    if (beat_idx_reg == LAST_IDX) begin
                        beat_idx_next  = 5'd0;
                        song_done_next = 1'b1;
                    end else begin
                        beat_idx_next = beat_idx_reg + 5'd1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs follow the state being entered; note/octave hold through LOAD and GAP
    always_comb begin
        note_next   = note_reg;
        octave_next = octave_reg;
        valid_raw   = 1'b0;
        case (state_next)
            S_IDLE: begin
                note_next   = 3'd0;
                octave_next = 2'd1;
            end
            S_MANUAL: begin
                note_next   = key_note;
                octave_next = bus.sw[0] ? 2'd2 : 2'd1;
                valid_raw   = 1'b1;
            end
            S_PLAY: begin
                if (state_reg == S_LOAD) begin
                    note_next   = rom_q[5:3];
                    octave_next = rom_q[7:6];
                end
                valid_raw = (note_next != 3'd0);
            end
            default: valid_raw = 1'b0;
        endcase
        note_valid_next = valid_raw & bus.sw[1];
        mode_next       = (state_next == S_LOAD) || (state_next == S_PLAY) || (state_next == S_GAP);
    end

    assign bus.note       = note_reg;
    assign bus.octave     = octave_reg;
    assign bus.note_valid = note_valid_reg;
    assign bus.mode       = mode_reg;
    assign bus.beat_idx   = beat_idx_reg;
    assign bus.song_done  = song_done_reg;
endmodule
